// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO responder: register offsets,
// TSTAT bit positions and reset values.
package dmem_pkg;

    localparam logic [5:0] OFS_LED      = 6'h00;
    localparam logic [5:0] OFS_SW       = 6'h04;
    localparam logic [5:0] OFS_MTIME_LO = 6'h08;
    localparam logic [5:0] OFS_MTIME_HI = 6'h0C;
    localparam logic [5:0] OFS_MTIMECMP = 6'h10;
    localparam logic [5:0] OFS_TSTAT    = 6'h14;

    localparam int unsigned TSTAT_FLAG_BIT = 0;
    localparam int unsigned TSTAT_IE_BIT   = 1;

    localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;
    localparam logic [15:0] LED_RST      = 16'h0000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static asynchronous inputs such as switches.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs at the same edge and form a true two-stage shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/data_mem_mmio.sv
// Memory-stage data responder: word RAM plus an MMIO window holding LEDs,
// synchronized switches and a 64-bit cycle timer with compare interrupt.
module data_mem_mmio
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        timer_irq_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [15:0]   r_led;
    logic [63:0]   r_mtime;
    logic [31:0]   r_mtimecmp;
    logic          r_flag;
    logic          r_ie;
    logic          r_irq;

    logic          w_ram_sel;
    logic          w_mmio_sel;
    logic [AW-1:0] w_idx;
    logic [5:0]    w_ofs;
    logic          w_wr_mmio;
    logic          w_wr_led;
    logic          w_wr_lo;
    logic          w_wr_hi;
    logic          w_wr_cmp;
    logic          w_wr_tstat;
    logic          w_match;
    logic          w_flag_nxt;
    logic          w_ie_nxt;
    logic [15:0]   w_sw_sync;
    logic [31:0]   w_rdata;
    logic          w_unused_lsb;

    // Byte lanes are not supported; the two address LSBs carry no meaning.
    assign w_unused_lsb = ^ALUResultM[1:0];

    assign w_ram_sel  = (ALUResultM[31:AW+2] == '0);
    assign w_idx      = ALUResultM[AW+1:2];
    assign w_mmio_sel = (ALUResultM[31:6] == MMIO_BASE[31:6]);
    assign w_ofs      = {ALUResultM[5:2], 2'b00};

    assign w_wr_mmio  = MemWriteM & w_mmio_sel;
    assign w_wr_led   = w_wr_mmio & (w_ofs == OFS_LED);
    assign w_wr_lo    = w_wr_mmio & (w_ofs == OFS_MTIME_LO);
    assign w_wr_hi    = w_wr_mmio & (w_ofs == OFS_MTIME_HI);
    assign w_wr_cmp   = w_wr_mmio & (w_ofs == OFS_MTIMECMP);
    assign w_wr_tstat = w_wr_mmio & (w_ofs == OFS_TSTAT);

    // Compare uses the pre-increment value; a new match beats a software clear.
    assign w_match    = (r_mtime[31:0] == r_mtimecmp);
    assign w_flag_nxt = w_match | (r_flag & ~(w_wr_tstat & WriteDataM[TSTAT_FLAG_BIT]));
    assign w_ie_nxt   = w_wr_tstat ? WriteDataM[TSTAT_IE_BIT] : r_ie;

    sync_2ff #(.WIDTH(16)) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .i_d (sw_i),
        .o_q (w_sw_sync)
    );

    // NOTE: the RAM has no reset so it maps onto plain memory macros/LUT-RAM,
    // and its contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (MemWriteM && w_ram_sel) begin
            r_mem[w_idx] <= WriteDataM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led      <= LED_RST;
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RST;
            r_flag     <= 1'b0;
            r_ie       <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_led) begin
                r_led <= WriteDataM[15:0];
            end
            if (w_wr_cmp) begin
                r_mtimecmp <= WriteDataM;
            end
            // A half-load freezes the counter for that cycle with no carry.
            if (w_wr_lo) begin
                r_mtime[31:0] <= WriteDataM;
            end else if (w_wr_hi) begin
                r_mtime[63:32] <= WriteDataM;
            end else begin
                r_mtime <= r_mtime + 64'd1;
            end
            r_flag <= w_flag_nxt;
            r_ie   <= w_ie_nxt;
            r_irq  <= w_flag_nxt & w_ie_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves w_rdata unassigned and no latch is inferred.
    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) begin
            w_rdata = r_mem[w_idx];
        end else if (w_mmio_sel) begin
            case (w_ofs)
                OFS_LED:      w_rdata = {16'h0000, r_led};
                OFS_SW:       w_rdata = {16'h0000, w_sw_sync};
                OFS_MTIME_LO: w_rdata = r_mtime[31:0];
                OFS_MTIME_HI: w_rdata = r_mtime[63:32];
                OFS_MTIMECMP: w_rdata = r_mtimecmp;
                OFS_TSTAT: begin
                    w_rdata[TSTAT_FLAG_BIT] = r_flag;
                    w_rdata[TSTAT_IE_BIT]   = r_ie;
                end
                default:      w_rdata = '0;
            endcase
        end
    end

    assign ReadDataM   = w_rdata;
    assign led_o       = r_led;
    assign timer_irq_o = r_irq;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios plus a randomized
// run scored against a behavioural model of the memory map and timer.
module tb_data_mem_mmio;

    localparam int          DEPTH     = 1024;
    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic        timer_irq_o;

    always #5 clk = ~clk;

    data_mem_mmio #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .MemWriteM   (MemWriteM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .ReadDataM   (ReadDataM),
        .sw_i        (sw_i),
        .led_o       (led_o),
        .timer_irq_o (timer_irq_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model of the architectural state.
    logic [31:0] m_mem [DEPTH];
    logic [15:0] m_led;
    logic [15:0] m_sw1, m_sw2;
    logic [63:0] m_mtime;
    logic [31:0] m_cmp;
    logic        m_flag, m_ie, m_irq;

    // Values sampled by the cycle driver.
    logic [31:0] s_rd, s_exp_rd;
    logic [15:0] s_led;
    logic        s_irq;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] ofs;
        if (a < DEPTH * 4) return m_mem[int'(a >> 2)];
        ofs = a - MMIO_BASE;
        if (ofs < 64) begin
            case (ofs >> 2)
                0:       return {16'h0000, m_led};
                1:       return {16'h0000, m_sw2};
                2:       return m_mtime[31:0];
                3:       return m_mtime[63:32];
                4:       return m_cmp;
                5:       return {30'h0, m_ie, m_flag};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_led = 16'h0; m_sw1 = 16'h0; m_sw2 = 16'h0;
        m_mtime = 64'h0; m_cmp = 32'hFFFF_FFFF;
        m_flag = 1'b0; m_ie = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ofs;
        int          reg_no;
        logic        match, clr;
        ofs    = a - MMIO_BASE;
        reg_no = (ofs < 64) ? int'(ofs >> 2) : -1;
        match  = (m_mtime[31:0] == m_cmp);
        clr    = we && reg_no == 5 && d[0];
        m_sw2  = m_sw1;
        m_sw1  = sw_i;
        if (we && a < DEPTH * 4) m_mem[int'(a >> 2)] = d;
        if (we && reg_no == 0) m_led = d[15:0];
        if (we && reg_no == 4) m_cmp = d;
        if (we && reg_no == 5) m_ie = d[1];
        m_flag = match || (m_flag && !clr);
        if (we && reg_no == 2)      m_mtime = {m_mtime[63:32], d};
        else if (we && reg_no == 3) m_mtime = {d, m_mtime[31:0]};
        else                        m_mtime = m_mtime + 64'd1;
        m_irq = m_flag && m_ie;
    endtask

    // One bus cycle: drive just after a rising edge, sample the read mid-cycle,
    // advance the model at the edge, then sample registered outputs.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = we;
        ALUResultM = a;
        WriteDataM = d;
        @(negedge clk);
        s_rd     = ReadDataM;
        s_exp_rd = model_read(a);
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        s_led     = led_o;
        s_irq     = timer_irq_o;
        MemWriteM = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [6];
        exp_v = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            ALUResultM = MMIO_BASE + 32'(i * 4);
            #1;
            n_total++;
            if (ReadDataM !== exp_v[i])
                $display("FAIL reset_reg%0d: got %h, want %h", i * 4, ReadDataM, exp_v[i]);
            else n_pass++;
        end
        n_total++;
        if (timer_irq_o !== 1'b0) $display("FAIL reset_irq: got %b, want 0", timer_irq_o);
        else n_pass++;
        n_total++;
        if (led_o !== 16'h0) $display("FAIL reset_led: got %h, want 0000", led_o);
        else n_pass++;
        ALUResultM = 32'h0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 32'h0, 32'h0);
        #1;
    endtask

    task automatic test_ram();
        cycle(1'b1, 32'h0000_0000, 32'h0BAD_F00D);
        cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        cycle(1'b0, 32'h0000_0010, 32'h0);
        n_total++;
        if (s_rd !== 32'hDEAD_BEEF) $display("FAIL ram_rd_10: got %h, want deadbeef", s_rd);
        else n_pass++;
        cycle(1'b0, 32'h0000_0013, 32'h0);
        n_total++;
        if (s_rd !== 32'hDEAD_BEEF) $display("FAIL ram_rd_13: got %h, want deadbeef", s_rd);
        else n_pass++;
        cycle(1'b1, 32'h0000_1000, 32'h5555_5555);
        n_total++;
        if (s_rd !== 32'h0) $display("FAIL unmapped_rd: got %h, want 00000000", s_rd);
        else n_pass++;
        cycle(1'b0, 32'h0000_0000, 32'h0);
        n_total++;
        if (s_rd !== 32'h0BAD_F00D) $display("FAIL ram_word0_kept: got %h, want 0badf00d", s_rd);
        else n_pass++;
        cycle(1'b1, 32'h0000_0020, 32'h1111_1111);
        cycle(1'b1, 32'h0000_0020, 32'h2222_2222);
        n_total++;
        if (s_rd !== 32'h1111_1111) $display("FAIL ram_rd_during_wr: got %h, want 11111111", s_rd);
        else n_pass++;
        cycle(1'b0, 32'h0000_0020, 32'h0);
        n_total++;
        if (s_rd !== 32'h2222_2222) $display("FAIL ram_rd_after_wr: got %h, want 22222222", s_rd);
        else n_pass++;
    endtask

    task automatic test_led_sw();
        cycle(1'b1, MMIO_BASE + 32'h00, 32'hFFFF_A5A5);
        n_total++;
        if (s_led !== 16'hA5A5) $display("FAIL led_out: got %h, want a5a5", s_led);
        else n_pass++;
        cycle(1'b0, MMIO_BASE + 32'h00, 32'h0);
        n_total++;
        if (s_rd !== 32'h0000_A5A5) $display("FAIL led_rd: got %h, want 0000a5a5", s_rd);
        else n_pass++;
        sw_i = 16'h1234;
        cycle(1'b0, MMIO_BASE + 32'h04, 32'h0);
        cycle(1'b0, MMIO_BASE + 32'h04, 32'h0);
        n_total++;
        if (s_rd !== 32'h0) $display("FAIL sw_after_1_edge: got %h, want 00000000", s_rd);
        else n_pass++;
        cycle(1'b0, MMIO_BASE + 32'h04, 32'h0);
        n_total++;
        if (s_rd !== 32'h0000_1234) $display("FAIL sw_after_2_edges: got %h, want 00001234", s_rd);
        else n_pass++;
    endtask

    task automatic test_mtime_carry();
        logic [31:0] exp_lo [3];
        exp_lo = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        cycle(1'b1, MMIO_BASE + 32'h08, 32'hFFFF_FFFE);
        cycle(1'b1, MMIO_BASE + 32'h0C, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, MMIO_BASE + 32'h08, 32'h0);
            n_total++;
            if (s_rd !== exp_lo[i]) $display("FAIL mtime_lo_%0d: got %h, want %h", i, s_rd, exp_lo[i]);
            else n_pass++;
        end
        cycle(1'b0, MMIO_BASE + 32'h0C, 32'h0);
        n_total++;
        if (s_rd !== 32'h1) $display("FAIL mtime_hi_carry: got %h, want 00000001", s_rd);
        else n_pass++;
        // The reset compare value matched at LO = FFFF_FFFF; IE is still 0.
        cycle(1'b0, MMIO_BASE + 32'h14, 32'h0);
        n_total++;
        if (s_rd !== 32'h1 || s_irq !== 1'b0)
            $display("FAIL flag_no_ie: got tstat=%h irq=%b, want tstat=00000001 irq=0", s_rd, s_irq);
        else n_pass++;
    endtask

    task automatic test_timer_irq();
        cycle(1'b1, MMIO_BASE + 32'h14, 32'h3);
        cycle(1'b1, MMIO_BASE + 32'h10, 32'd100);
        cycle(1'b1, MMIO_BASE + 32'h08, 32'd95);
        n_total++;
        if (s_irq !== 1'b0) $display("FAIL irq_at_load: got %b, want 0", s_irq);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, MMIO_BASE + 32'h08, 32'h0);
            n_total++;
            if (s_rd !== 32'(94 + k) || s_irq !== (k >= 6))
                $display("FAIL irq_edge_%0d: got lo=%0d irq=%b, want lo=%0d irq=%b",
                         k, s_rd, s_irq, 94 + k, (k >= 6));
            else n_pass++;
        end
        cycle(1'b1, MMIO_BASE + 32'h14, 32'h3);
        n_total++;
        if (s_irq !== 1'b0) $display("FAIL irq_clear: got %b, want 0", s_irq);
        else n_pass++;
        cycle(1'b0, MMIO_BASE + 32'h14, 32'h0);
        n_total++;
        if (s_rd !== 32'h2) $display("FAIL tstat_after_clear: got %h, want 00000002", s_rd);
        else n_pass++;
    endtask

    task automatic test_collision_reset();
        cycle(1'b1, MMIO_BASE + 32'h08, 32'd200);
        cycle(1'b1, MMIO_BASE + 32'h10, 32'd203);
        cycle(1'b0, MMIO_BASE + 32'h08, 32'h0);
        cycle(1'b0, MMIO_BASE + 32'h08, 32'h0);
        cycle(1'b1, MMIO_BASE + 32'h14, 32'h3);
        n_total++;
        if (s_rd !== 32'h2 || s_irq !== 1'b1)
            $display("FAIL collision: got tstat=%h irq=%b, want tstat=00000002 irq=1", s_rd, s_irq);
        else n_pass++;
        cycle(1'b0, MMIO_BASE + 32'h14, 32'h0);
        n_total++;
        if (s_rd !== 32'h3) $display("FAIL collision_flag: got %h, want 00000003", s_rd);
        else n_pass++;
        // Asynchronous reset in the middle of a cycle.
        ALUResultM = MMIO_BASE + 32'h08;
        #3 rst = 1'b0;
        #1;
        n_total++;
        if (timer_irq_o !== 1'b0 || ReadDataM !== 32'h0 || led_o !== 16'h0)
            $display("FAIL async_reset: got irq=%b lo=%h led=%h, want irq=0 lo=00000000 led=0000",
                     timer_irq_o, ReadDataM, led_o);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        ALUResultM = 32'h0000_0010;
        #1;
        n_total++;
        if (ReadDataM !== 32'hDEAD_BEEF) $display("FAIL ram_kept_in_reset: got %h, want deadbeef", ReadDataM);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 32'h0, 32'h0);
        #1;
        cycle(1'b0, MMIO_BASE + 32'h08, 32'h0);
        n_total++;
        if (s_rd !== 32'h1) $display("FAIL mtime_after_reset: got %h, want 00000001", s_rd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        we;
        for (int i = 16; i < 32; i++) cycle(1'b1, 32'(i * 4), $urandom);
        for (int n = 0; n < 300; n++) begin
            sw_i = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       a = ($urandom_range(16, 31) << 2) | $urandom_range(0, 3);
                1:       a = MMIO_BASE + $urandom_range(0, 63);
                2:       a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
                default: a = 32'h0000_1000 + $urandom_range(0, 4095);
            endcase
            we = ($urandom_range(0, 2) == 0);
            d  = $urandom;
            cycle(we, a, d);
            n_total++;
            if (s_rd !== s_exp_rd || s_led !== m_led || s_irq !== m_irq)
                $display("FAIL rand_%0d addr=%h we=%b: got rd=%h led=%h irq=%b, want rd=%h led=%h irq=%b",
                         n, a, we, s_rd, s_led, s_irq, s_exp_rd, m_led, m_irq);
            else n_pass++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        sw_i       = 16'h0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        test_reset();
        test_ram();
        test_led_sw();
        test_mtime_carry();
        test_timer_irq();
        test_collision_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-memory responder for the pipelined RISC-V core, sitting on the Memory-stage bus. It is the other end of the core's data-memory interface: it decodes `ALUResultM`, commits `WriteDataM` on `MemWriteM`, and returns `ReadDataM` in the same cycle for capture into the Writeback register. It contains a word-addressed RAM and a small MMIO block with:
- LED output register
- synchronized switch input
- 64-bit free-running cycle timer with compare flag and interrupt

## Interface
Parameters:
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, ≥ 4.
- `MMIO_BASE`, 32'h1000_0000: base address of the MMIO window (64-byte aligned).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `MemWriteM`  in  1  write strobe for the current M-stage access.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  write data.
- `ReadDataM`  out  32  read data; combinational from address and state.
- `sw_i`  in  16  asynchronous switch pins.
- `led_o`  out  16  LED register.
- `timer_irq_o`  out  1  timer interrupt, registered.

## Operation
- `ALUResultM[1:0]` is ignored; every access is a full word.
- **RAM decode.** Selected when `ALUResultM[31:$clog2(DEPTH)+2] == 0`.
  - Word index is `ALUResultM[$clog2(DEPTH)+1:2]`.
  - RAM has no reset; simulation initializes it to 0.
- **MMIO decode.** Selected when `ALUResultM[31:6] == MMIO_BASE[31:6]`. Offsets:
  - 0x00 `LED`: RW; bits [15:0] drive `led_o`; upper bits read 0.
  - 0x04 `SW`: RO; synchronized `sw_i` in bits [15:0]; writes ignored.
  - 0x08 `MTIME_LO`: RW; `mtime[31:0]`.
  - 0x0C `MTIME_HI`: RW; `mtime[63:32]`. There is no snapshot; software re-reads HI to detect a carry.
  - 0x10 `MTIMECMP`: RW; 32-bit compare value.
  - 0x14 `TSTAT`: bit0 = FLAG (read; write 1 clears), bit1 = IE (RW). Other bits read 0.
- **Unmapped access.** Reads return 0; writes are ignored. An unused MMIO offset counts as unmapped.
- **mtime.**
  - Increments by 1 every cycle and wraps from 2^64−1 to 0.
  - A write to LO or HI loads that half, and `mtime` does not increment that cycle. The other half holds its value, with no carry.
- **FLAG.**
  - Set on the edge after a cycle in which `mtime[31:0] == MTIMECMP`. The comparison uses the pre-increment value.
  - Sticky until software writes 1 to `TSTAT` bit0.
  - If set and clear happen in the same cycle, set wins.
- **`timer_irq_o`.** Registered `FLAG & IE`, using the next-state values of both.
- **Reset values (asynchronous, on `rst` low).**
  - `led_o` = 0, `mtime` = 0, `MTIMECMP` = 32'hFFFF_FFFF, FLAG = 0, IE = 0, `timer_irq_o` = 0.
  - Both synchronizer stages = 0.
  - `ReadDataM` reflects these reset values combinationally.
- **Reset mid-operation.** All registers listed above clear immediately. RAM contents are retained.

## Timing
- Read latency is 0 cycles: `ReadDataM` is valid in the same cycle as `ALUResultM`.
- A write commits at the rising edge where `MemWriteM` = 1. A read of the same address in the next cycle returns the new data.
- A read in the same cycle as a write to the same address returns the old data.
- A `MTIME_LO` read returns the current, pre-increment value. Back-to-back reads in consecutive cycles differ by 1.
- `SW` lags `sw_i` by 2 rising edges.
- If `MTIMECMP` = N and `mtime[31:0]` = N in cycle t, FLAG = 1 from cycle t+1 and `timer_irq_o` = 1 from cycle t+1 (when IE = 1).
- A write of 1 to `TSTAT` bit0 in cycle t gives FLAG = 0 and `timer_irq_o` = 0 from cycle t+1, unless a new match occurs in cycle t.

## Structure
- Package `dmem_pkg` holds:
  - offset localparams `OFS_LED`, `OFS_SW`, `OFS_MTIME_LO`, `OFS_MTIME_HI`, `OFS_MTIMECMP`, `OFS_TSTAT`;
  - the `TSTAT` bit indices;
  - reset constants `MTIMECMP_RST`, `LED_RST`.
- Sub-module `sync_2ff` (parameter `WIDTH`) provides the switch synchronizer, with the same `clk` and `rst` semantics.
- RAM is an inferred array in this module with synchronous write and asynchronous read.

## Test plan
- **Reset values.** Hold `rst` = 0 and read every MMIO offset. Expect LED = 0, `MTIMECMP` = 32'hFFFF_FFFF, `TSTAT` = 0, and `timer_irq_o` = 0.
- **RAM write/read.** Write 32'hDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013: both return DEAD_BEEF. Read 0x0000_1000 (unmapped at `DEPTH` = 1024): returns 0. A write there leaves RAM word 0 unchanged.
- **LED and switch path.** Write 32'hFFFF_A5A5 to `LED`: `led_o` = 16'hA5A5 on the next cycle and `LED` reads 32'h0000_A5A5. Set `sw_i` = 16'h1234: the `SW` read shows 0x1234 exactly 2 edges later.
- **mtime load and carry.** Write `MTIME_LO` = 32'hFFFF_FFFE and `MTIME_HI` = 0 in consecutive cycles. The `HI` write holds LO. Then after 2 cycles, `HI` = 1 and `LO` = 0.
- **Timer interrupt.** Set IE = 1 and `MTIMECMP` = 100, then load `MTIME_LO` = 95. `timer_irq_o` rises 6 cycles after the load edge. Write 1 to `TSTAT` bit0: IRQ drops the next cycle.
- **Set/clear collision, then reset.** Clear FLAG in the same cycle as a match: FLAG stays 1. Then assert `rst` mid-run: IRQ and `mtime` clear asynchronously, and RAM word 0x10 still reads DEAD_BEEF.
